// File: rtl/core_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package core_pkg;

  localparam int unsigned ILEN_DEFAULT = 32;
  localparam int unsigned LINE_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ifetch_state_t;

  typedef logic [3:0][ILEN_DEFAULT-1:0] iline_t;

endpackage

// File: rtl/ifetch_line.sv
// Instruction-line fetch stage feeding the instruction queue.
// Walks a line-aligned PC, requests 16-byte lines over req/gnt/rval, buffers
// one returned line and pushes it whole into the queue. Redirects retarget the
// PC and drop stale fetches.
// Optional build macro IFETCH_PERF_EN adds saturating perf_lines/perf_stall
// counters.
module ifetch_line
  import core_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      ILEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redir_val,
  input  logic [XLEN-1:0]      redir_pc,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rval,
  input  logic [4*ILEN-1:0]    imem_rdata,
  input  logic                 fq_full,
  output logic                 fq_psh,
  output logic [3:0][ILEN-1:0] fq_din,
  output logic [1:0]           fq_ofs
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]          perf_lines,
  output logic [31:0]          perf_stall
`endif
);

  typedef logic [3:0][ILEN-1:0] line_t;

  ifetch_state_t   state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            buf_val_q, buf_val_d;
  line_t           buf_q, buf_d;
  logic [1:0]      buf_ofs_q, buf_ofs_d;
  logic [1:0]      ofs_pend_q, ofs_pend_d;
  logic [XLEN-1:0] redir_line;
  logic            unused_redir_lsb;

  // pc is kept line-aligned at all times, so it drives imem_addr directly
  assign redir_line       = {redir_pc[XLEN-1:4], 4'b0000};
  assign unused_redir_lsb = ^redir_pc[1:0];
  assign imem_addr        = pc_q;
  assign fq_din           = buf_q;
  assign fq_ofs           = buf_ofs_q;

  // Queue push and memory request qualification
  always_comb begin
    fq_psh   = buf_val_q & ~fq_full & ~redir_val;
    imem_req = (state_q == REQ) & (~buf_val_q | fq_psh);
  end

  // Next-state, pc and line-buffer update; redirect handling overrides last
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_val_d  = buf_val_q;
    buf_d      = buf_q;
    buf_ofs_d  = buf_ofs_q;
    ofs_pend_d = ofs_pend_q;

    if (fq_psh) buf_val_d = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req && imem_gnt) begin
          state_d = WAIT;
          pc_d    = pc_q + XLEN'(LINE_BYTES);
        end
      end
      WAIT: begin
        if (imem_rval) begin
          buf_d      = imem_rdata;
          buf_val_d  = 1'b1;
          buf_ofs_d  = ofs_pend_q;
          ofs_pend_d = 2'b00;
          state_d    = REQ;
        end
      end
      DRAIN: begin
        if (imem_rval) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // A redirect in DRAIN that coincides with the stale response still leaves
    // to REQ: the one outstanding response has been consumed, so staying in
    // DRAIN would wait for data that never arrives.
    if (redir_val) begin
      buf_val_d  = 1'b0;
      pc_d       = redir_line;
      ofs_pend_d = redir_pc[3:2];
      case (state_q)
        REQ:     state_d = (imem_req && imem_gnt) ? DRAIN : REQ;
        WAIT:    state_d = imem_rval ? REQ : DRAIN;
        DRAIN:   state_d = imem_rval ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end
  end

  // State, pc and line-buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= {RESET_PC[XLEN-1:4], 4'b0000};
      buf_val_q  <= 1'b0;
      buf_q      <= '0;
      buf_ofs_q  <= 2'b00;
      ofs_pend_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_val_q  <= buf_val_d;
      buf_q      <= buf_d;
      buf_ofs_q  <= buf_ofs_d;
      ofs_pend_q <= ofs_pend_d;
    end
  end

`ifdef IFETCH_PERF_EN
  // Saturating counters of pushed lines and queue-full stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lines <= '0;
      perf_stall <= '0;
    end else begin
      if (fq_psh && (perf_lines != '1)) perf_lines <= perf_lines + 32'd1;
      if (buf_val_q && fq_full && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_line.sv
// Self-checking bench for ifetch_line: directed vector table, hand-written
// reset/wrap sequences, and a randomized run against a line-stream model.
module tb_ifetch_line;

  logic         clk;
  logic         rst_n;
  logic         redir_val;
  logic [31:0]  redir_pc;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rval;
  logic [127:0] imem_rdata;
  logic         fq_full;
  logic         fq_psh;
  logic [3:0][31:0] fq_din;
  logic [1:0]   fq_ofs;

  logic         w_rst_n;
  logic         w_gnt;
  logic         w_rval;
  logic [127:0] w_rdata;
  logic         w_req;
  logic [31:0]  w_addr;
  logic         w_psh;
  logic [3:0][31:0] w_din;
  logic [1:0]   w_ofs;
  logic         w_zero;
  logic [31:0]  w_zero_pc;

`ifdef IFETCH_PERF_EN
  logic [31:0]  perf_lines, perf_stall;
  logic [31:0]  w_perf_lines, w_perf_stall;
`endif

  int checks;
  int failures;

  ifetch_line #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .redir_val(redir_val), .redir_pc(redir_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rval(imem_rval), .imem_rdata(imem_rdata),
    .fq_full(fq_full), .fq_psh(fq_psh), .fq_din(fq_din), .fq_ofs(fq_ofs)
`ifdef IFETCH_PERF_EN
    , .perf_lines(perf_lines), .perf_stall(perf_stall)
`endif
  );

  ifetch_line #(.XLEN(32), .ILEN(32), .RESET_PC(32'hFFFF_FFF0)) u_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .redir_val(w_zero), .redir_pc(w_zero_pc),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rval(w_rval), .imem_rdata(w_rdata),
    .fq_full(w_zero), .fq_psh(w_psh), .fq_din(w_din), .fq_ofs(w_ofs)
`ifdef IFETCH_PERF_EN
    , .perf_lines(w_perf_lines), .perf_stall(w_perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] line_data(input logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a} ^ {4{32'h9E37_79B9}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        gnt;
    logic        rval;
    logic        full;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] rd_addr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_psh;
    logic [31:0] exp_daddr;
    logic [1:0]  exp_ofs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic g, input logic rv, input logic f, input logic rd,
                              input logic [31:0] rpc, input logic [31:0] rda,
                              input logic er, input logic [31:0] ea, input logic ep,
                              input logic [31:0] eda, input logic [1:0] eo);
    vec_t v;
    v.gnt = g; v.rval = rv; v.full = f; v.redir = rd; v.rpc = rpc; v.rd_addr = rda;
    v.exp_req = er; v.exp_addr = ea; v.exp_psh = ep; v.exp_daddr = eda; v.exp_ofs = eo;
    return v;
  endfunction

  // randomized-phase model state
  logic [31:0] exp_addr;
  logic [1:0]  exp_ofs;
  logic        out_valid;
  logic [31:0] out_addr;
  int unsigned lat;
  int          pushes;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; w_rst_n = 1'b0; w_zero = 1'b0; w_zero_pc = '0;
    redir_val = 0; redir_pc = '0; imem_gnt = 0; imem_rval = 0; imem_rdata = '0; fq_full = 0;
    w_gnt = 0; w_rval = 0; w_rdata = '0;

    // gnt/rval 1-cycle, full stall, redirect in WAIT, redirect with rval, redirect in REQ
    tbl.push_back(mk(0,0,0,0,0,0,            0,32'h0,   0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,            1,32'h0,   0,0,0));
    tbl.push_back(mk(0,1,0,0,0,32'h0,        0,32'h10,  0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,            1,32'h10,  1,32'h0,0));
    tbl.push_back(mk(0,1,0,0,0,32'h10,       0,32'h20,  0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,            1,32'h20,  1,32'h10,0));
    tbl.push_back(mk(0,1,0,0,0,32'h20,       0,32'h30,  0,0,0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1,0,1,0,0,0,          0,32'h30,  0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,            1,32'h30,  1,32'h20,0));
    tbl.push_back(mk(0,0,0,1,32'h1008,0,     0,32'h40,  0,0,0));
    tbl.push_back(mk(0,1,0,0,0,32'h30,       0,32'h1000,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,            1,32'h1000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,32'h1000,     0,32'h1010,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,            1,32'h1010,1,32'h1000,2));
    tbl.push_back(mk(0,1,0,1,32'h200,32'h1010,0,32'h1020,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,            1,32'h200, 0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h40,0,       1,32'h200, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,            1,32'h40,  0,0,0));
    tbl.push_back(mk(0,1,0,0,0,32'h40,       0,32'h50,  0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,            1,32'h50,  1,32'h40,0));

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",  imem_req,  0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_psh",  fq_psh,    0);
    chk("rst_ofs",  fq_ofs,    0);
    chk("rst_din",  fq_din,    '0);

    // directed vector table, first row applied in the cycle reset is released
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      imem_gnt   = tbl[i].gnt;
      imem_rval  = tbl[i].rval;
      imem_rdata = tbl[i].rval ? line_data(tbl[i].rd_addr) : 128'hDEAD;
      fq_full    = tbl[i].full;
      redir_val  = tbl[i].redir;
      redir_pc   = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d_req", i),  imem_req,  tbl[i].exp_req);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_psh", i),  fq_psh,    tbl[i].exp_psh);
      if (tbl[i].exp_psh) begin
        chk($sformatf("v%0d_din", i), fq_din, line_data(tbl[i].exp_daddr));
        chk($sformatf("v%0d_ofs", i), fq_ofs, tbl[i].exp_ofs);
      end
      @(negedge clk);
    end

    // asynchronous reset mid-operation
    imem_gnt = 0; imem_rval = 0; fq_full = 0; redir_val = 0;
    #1;
    chk("pre_arst_req",  imem_req,  1);
    chk("pre_arst_addr", imem_addr, 32'h50);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",  imem_req,  0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_din",  fq_din,    '0);

    // pc wrap-around from the top line of the address space
    @(negedge clk);
    w_rst_n = 1'b1;
    #1;
    chk("wrap_idle_req", w_req, 0);
    @(negedge clk);
    w_gnt = 1;
    #1;
    chk("wrap_req0",  w_req,  1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFF0);
    @(negedge clk);
    w_gnt = 0; w_rval = 1; w_rdata = line_data(32'hFFFF_FFF0);
    #1;
    chk("wrap_wait_addr", w_addr, 32'h0);
    @(negedge clk);
    w_rval = 0; w_gnt = 1;
    #1;
    chk("wrap_psh",   w_psh,  1);
    chk("wrap_din",   w_din,  line_data(32'hFFFF_FFF0));
    chk("wrap_req1",  w_req,  1);
    chk("wrap_addr1", w_addr, 32'h0);
    @(negedge clk);
    w_gnt = 0;

    // randomized run against the line-stream model
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = 32'h0; exp_ofs = 2'b00;
    out_valid = 0; out_addr = '0; lat = 0; pushes = 0;
    for (int c = 0; c < 4000; c++) begin
      imem_rval  = out_valid && (lat == 0);
      imem_rdata = imem_rval ? line_data(out_addr) : {$urandom, $urandom, $urandom, $urandom};
      imem_gnt   = ($urandom_range(0, 1) == 1);
      fq_full    = ($urandom_range(0, 3) == 0);
      redir_val  = ($urandom_range(0, 15) == 0);
      redir_pc   = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                               : ($urandom & 32'h0000_0FFC);
      #1;
      chk("rnd_one_outstanding", imem_req & out_valid, 0);
      if (imem_req) chk("rnd_addr_align", imem_addr[3:0], 4'h0);
      if (fq_psh) begin
        chk("rnd_psh_legal", fq_full | redir_val, 0);
        chk("rnd_din", fq_din, line_data(exp_addr));
        chk("rnd_ofs", fq_ofs, exp_ofs);
        exp_addr = exp_addr + 32'd16;
        exp_ofs  = 2'b00;
        pushes++;
      end
      if (redir_val) begin
        exp_addr = {redir_pc[31:4], 4'h0};
        exp_ofs  = redir_pc[3:2];
      end
      if (imem_rval) out_valid = 0;
      else if (out_valid && lat > 0) lat--;
      if (imem_req && imem_gnt) begin
        out_valid = 1;
        out_addr  = imem_addr;
        lat       = $urandom_range(0, 3);
      end
      @(negedge clk);
`ifdef IFETCH_PERF_EN
      #1;
      chk("rnd_perf_lines", perf_lines, pushes);
`endif
    end
    chk("rnd_progress", (pushes > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
